bcd_counter_display: RTL

//  Parametrised N-digit BCD up/down counter with a multiplexed 7-segment display driver.

---
 rtl/bcd_counter_display.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bcd_counter_display.sv
// rtl/bcd_counter_display.sv - N-digit BCD up/down counter with multiplexed 7-segment driver
module bcd_counter_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int NUM_AN_TOTAL = 8,
  parameter int TICK_DIV     = 1,
  parameter int REFRESH_DIV  = 4,
  localparam int DPW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             up_dn,
  input  logic                             load,
  input  logic [4*NUM_DIGITS-1:0]          load_val,
  input  logic                             cathod,
  input  logic                             blank_lz,
  input  logic [DPW-1:0]                   dp_pos,
  output logic [4*NUM_DIGITS-1:0]          digits,
  output logic                             wrap,
  output logic [6:0]                       seg,
  output logic                             dp,
  output logic [NUM_DIGITS-1:0]            an,
  output logic [NUM_AN_TOTAL-NUM_DIGITS-1:0] other_an
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0]  REF_MAX   = RW'(REFRESH_DIV - 1);
  localparam logic [DPW-1:0] IDX_MAX   = DPW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] count;
  logic [4*NUM_DIGITS-1:0] step_val;
  logic [4*NUM_DIGITS-1:0] load_clean;
  logic                    step_cy;
  logic [PW-1:0]           presc;
  logic                    tick;

  logic [RW-1:0]           ref_cnt;
  logic [DPW-1:0]          scan_idx;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_run;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_pat;

  logic [6:0]              seg_int;
  logic                    dp_int;
  logic [NUM_DIGITS-1:0]   an_int;

  assign tick = en && (presc == PRESC_MAX);

  // Carry/borrow ripples through every digit within one cycle.
  always_comb begin
    step_val = count;
    step_cy  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (step_cy) begin
        if (up_dn) begin
          if (count[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
            step_cy            = 1'b0;
          end
        end else begin
          if (count[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
            step_cy            = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    load_clean = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      presc <= '0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count <= load_clean;
        presc <= '0;
      end else begin
        if (en) presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          count <= step_val;
          wrap  <= step_cy;
        end
      end
    end
  end

  assign digits = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt  <= '0;
      scan_idx <= '0;
    end else if (ref_cnt == REF_MAX) begin
      ref_cnt  <= '0;
      scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // A digit is blanked only while it and everything above it are zero.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (count[4*i +: 4] == 4'd0);
      blank_mask[i] = blank_lz && (i > 0) && zero_run;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_next   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == DPW'(i)) begin
        cur_digit  = count[4*i +: 4];
        cur_blank  = blank_mask[i];
        an_next[i] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_pat = 7'h00;
    case (cur_digit)
      4'd0: seg_pat = 7'h3F;
      4'd1: seg_pat = 7'h06;
      4'd2: seg_pat = 7'h5B;
      4'd3: seg_pat = 7'h4F;
      4'd4: seg_pat = 7'h66;
      4'd5: seg_pat = 7'h6D;
      4'd6: seg_pat = 7'h7D;
      4'd7: seg_pat = 7'h07;
      4'd8: seg_pat = 7'h7F;
      4'd9: seg_pat = 7'h6F;
      default: seg_pat = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_int <= '0;
      dp_int  <= 1'b0;
      an_int  <= '0;
    end else begin
      seg_int <= cur_blank ? 7'h00 : seg_pat;
      dp_int  <= (scan_idx == dp_pos);
      an_int  <= an_next;
    end
  end

  // Polarity stage is combinational so cathod acts in the same cycle.
  assign seg      = cathod ? seg_int : ~seg_int;
  assign dp       = cathod ? dp_int  : ~dp_int;
  assign an       = cathod ? an_int  : ~an_int;
  assign other_an = cathod ? '0 : '1;

endmodule
